// File: rtl/temporal_window_ctrl_if.sv
// Handshake and control bundle between a temporal window controller and its
// surroundings: window control, upstream source, temporal encoder and downstream sink.
interface temporal_window_ctrl_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 Start_SI;
  logic                 Abort_SI;
  logic [CNT_WIDTH-1:0] WindowLen_DI;
  logic                 Busy_SO;
  logic                 Done_SO;
  logic                 ValidIn_SI;
  logic                 ReadyOut_SO;
  logic                 EncValid_SO;
  logic                 EncReady_SI;
  logic                 EncValidOut_SI;
  logic                 EncReadyIn_SO;
  logic                 EncClear_SO;
  logic                 ValidOut_SO;
  logic                 ReadyIn_SI;
  logic                 LastOut_SO;

  modport slave (
    input  Start_SI, Abort_SI, WindowLen_DI, ValidIn_SI, EncReady_SI,
           EncValidOut_SI, ReadyIn_SI,
    output Busy_SO, Done_SO, ReadyOut_SO, EncValid_SO, EncReadyIn_SO,
           EncClear_SO, ValidOut_SO, LastOut_SO
  );

  modport master (
    output Start_SI, Abort_SI, WindowLen_DI, ValidIn_SI, EncReady_SI,
           EncValidOut_SI, ReadyIn_SI,
    input  Busy_SO, Done_SO, ReadyOut_SO, EncValid_SO, EncReadyIn_SO,
           EncClear_SO, ValidOut_SO, LastOut_SO
  );
endinterface

// File: rtl/temporal_window_ctrl.sv
// Sequences one temporal encoder over a window of spatial hypervectors: clears its
// history, admits WindowLen inputs, drops the NGRAM-1 warm-up outputs, flags the last.
`ifndef NGRAM_SIZE
`define NGRAM_SIZE 4
`endif

// state | meaning
// IDLE  | waiting for Start
// CLEAR | one-cycle encoder history clear
// RUN   | admitting inputs, draining/forwarding encoder outputs
// ABORT | one-cycle clear after an abandoned window
// DONE  | one-cycle completion pulse
module temporal_window_ctrl #(
  parameter int NGRAM     = `NGRAM_SIZE,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  Clk_CI,
  input  logic                  Reset_RI,
  temporal_window_ctrl_if.slave win
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] ABORT = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [CNT_WIDTH-1:0] WARMUP_LEN = CNT_WIDTH'(NGRAM - 1);

  logic [2:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] win_len_q, in_cnt_q, out_cnt_q;
  logic                 run, in_open, warm_up, at_last, in_fire, out_fire;

  assign run     = (state_q == RUN);
  assign in_open = (in_cnt_q < win_len_q);
  assign warm_up = (out_cnt_q < WARMUP_LEN);
  assign at_last = (out_cnt_q == win_len_q - CNT_WIDTH'(1));

  assign win.Busy_SO       = (state_q != IDLE);
  assign win.Done_SO       = (state_q == DONE);
  assign win.EncClear_SO   = (state_q == CLEAR) || (state_q == ABORT);
  assign win.EncValid_SO   = run & in_open & win.ValidIn_SI;
  assign win.ReadyOut_SO   = run & in_open & win.EncReady_SI;
  // Warm-up outputs are swallowed here, so the encoder never waits on downstream for them.
  assign win.EncReadyIn_SO = run & (warm_up | win.ReadyIn_SI);
  assign win.ValidOut_SO   = run & ~warm_up & win.EncValidOut_SI;
  assign win.LastOut_SO    = win.ValidOut_SO & at_last;

  assign in_fire  = win.ValidIn_SI & win.ReadyOut_SO;
  assign out_fire = win.EncValidOut_SI & win.EncReadyIn_SO;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (win.Start_SI) state_d = (win.WindowLen_DI == '0) ? DONE : CLEAR;
      end
      CLEAR: state_d = win.Abort_SI ? ABORT : RUN;
      RUN: begin
        if (win.Abort_SI)             state_d = ABORT;
        else if (out_fire && at_last) state_d = DONE;
      end
      ABORT:   state_d = IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      state_q   <= IDLE;
      win_len_q <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (win.Start_SI && (win.WindowLen_DI != '0)) win_len_q <= win.WindowLen_DI;
        end
        CLEAR: begin
          in_cnt_q  <= '0;
          out_cnt_q <= '0;
        end
        RUN: begin
          if (in_fire)              in_cnt_q  <= in_cnt_q + CNT_WIDTH'(1);
          // The final fire leaves OutCnt at WinLen-1; the window closes instead.
          if (out_fire && !at_last) out_cnt_q <= out_cnt_q + CNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_temporal_window_ctrl.sv
// Randomized bench for temporal_window_ctrl: a FIFO stands in for the temporal encoder,
// and a scoreboard of expected forwarded items is checked by an independent monitor.
module tb_temporal_window_ctrl;
  localparam int NGRAM = 4;
  localparam int CW    = 16;

  typedef struct {
    int id;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  temporal_window_ctrl_if #(.CNT_WIDTH(CW)) win ();

  temporal_window_ctrl #(.NGRAM(NGRAM), .CNT_WIDTH(CW)) dut (
    .Clk_CI  (clk),
    .Reset_RI(rst),
    .win     (win)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  int   done_expected = 0;
  int   enc_fifo[$];
  int   enc_head = -1;
  int   p_valid = 100, p_enc = 100, p_ready = 100;
  bit   quiet = 1'b1;
  int   stall_left = 0;
  int   in_acc = 0, enc_out = 0, clr_cnt = 0;
  bit   prev_stall = 1'b0, prev_done = 1'b0;

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [7:0] out_vec();
    return {win.Busy_SO, win.Done_SO, win.ReadyOut_SO, win.EncValid_SO,
            win.EncReadyIn_SO, win.EncClear_SO, win.ValidOut_SO, win.LastOut_SO};
  endfunction

  // Source, encoder stand-in and sink, all driven just after the rising edge.
  task automatic drive_inputs();
    if (quiet) begin
      win.ValidIn_SI     = 1'b0;
      win.EncReady_SI    = 1'b0;
      win.EncValidOut_SI = 1'b0;
      win.ReadyIn_SI     = 1'b0;
      enc_head           = -1;
    end else begin
      win.ValidIn_SI     = (int'($urandom_range(99)) < p_valid);
      win.EncReady_SI    = (enc_fifo.size() < 2) && (int'($urandom_range(99)) < p_enc);
      win.EncValidOut_SI = (enc_fifo.size() > 0);
      enc_head           = (enc_fifo.size() > 0) ? enc_fifo[0] : -1;
      if (stall_left > 0 && enc_out == NGRAM - 1 && enc_fifo.size() > 0) begin
        win.ReadyIn_SI = 1'b0;
        stall_left--;
      end else begin
        win.ReadyIn_SI = (int'($urandom_range(99)) < p_ready);
      end
    end
  endtask

  task automatic sample();
    logic up_fire, enc_in_fire, enc_out_fire;
    up_fire      = win.ValidIn_SI & win.ReadyOut_SO;
    enc_in_fire  = win.EncValid_SO & win.EncReady_SI;
    enc_out_fire = win.EncValidOut_SI & win.EncReadyIn_SO;
    chk1("upstream_vs_encoder_accept", up_fire, enc_in_fire);
    if (enc_out_fire) begin
      void'(enc_fifo.pop_front());
      enc_out++;
    end
    if (enc_in_fire) enc_fifo.push_back(in_acc);
    if (up_fire) in_acc++;
    if (win.EncClear_SO) begin
      clr_cnt++;
      enc_fifo.delete();
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_inputs();
    @(negedge clk);
    sample();
  endtask

  task automatic run_window(int len, int stall, int abort_after, bit busy_start);
    int cyc;
    bit pulsed;
    pulsed     = 1'b0;
    in_acc     = 0;
    enc_out    = 0;
    clr_cnt    = 0;
    stall_left = stall;
    for (int k = NGRAM - 1; k < len; k++) exp_q.push_back('{k, (k == len - 1)});
    done_expected++;
    win.WindowLen_DI = CW'(len);
    win.Start_SI     = 1'b1;
    step();
    win.Start_SI     = 1'b0;
    win.WindowLen_DI = CW'($urandom_range(40));
    if (len == 0) begin
      chk1("len0_done_next_cycle", win.Done_SO, 1'b1);
      chk1("len0_no_clear", win.EncClear_SO, 1'b0);
    end else begin
      chk1("clear_after_start", win.EncClear_SO, 1'b1);
    end
    for (cyc = 0; cyc < 3000 && win.Busy_SO; cyc++) begin
      if (busy_start && !pulsed && in_acc == 1) begin
        win.Start_SI     = 1'b1;
        win.WindowLen_DI = CW'(2);
        pulsed           = 1'b1;
      end
      if (abort_after >= 0 && in_acc == abort_after) begin
        win.Abort_SI  = 1'b1;
        exp_q.delete();
        done_expected = 0;
        step();
        win.Abort_SI = 1'b0;
        win.Start_SI = 1'b0;
        chk1("abort_clear", win.EncClear_SO, 1'b1);
        chk1("abort_busy", win.Busy_SO, 1'b1);
        chk("abort_handshakes", int'({win.ReadyOut_SO, win.EncValid_SO,
                                      win.EncReadyIn_SO, win.ValidOut_SO}), 0);
        step();
        chk1("abort_back_idle", win.Busy_SO, 1'b0);
        chk("abort_clear_pulses", clr_cnt, 2);
        step();
        return;
      end
      step();
      win.Start_SI = 1'b0;
    end
    chk("window_timeout", (cyc < 3000) ? 1 : 0, 1);
    chk("inputs_admitted", in_acc, len);
    chk("encoder_outputs_consumed", enc_out, len);
    chk("clear_pulses", clr_cnt, (len > 0) ? 1 : 0);
    chk("outputs_outstanding", exp_q.size(), 0);
    if (stall > 0) chk("stall_applied", stall_left, 0);
    step();
  endtask

  task automatic reset_mid_run();
    int cyc;
    in_acc  = 0;
    enc_out = 0;
    clr_cnt = 0;
    win.WindowLen_DI = CW'(8);
    win.Start_SI     = 1'b1;
    step();
    win.Start_SI = 1'b0;
    for (cyc = 0; cyc < 200 && in_acc < 3; cyc++) step();
    chk("reset_setup_timeout", (cyc < 200) ? 1 : 0, 1);
    rst   = 1'b1;
    quiet = 1'b1;
    exp_q.delete();
    done_expected = 0;
    step();
    chk("reset_outputs_c1", int'(out_vec()), 0);
    step();
    chk("reset_outputs_c2", int'(out_vec()), 0);
    rst   = 1'b0;
    enc_fifo.delete();
    quiet = 1'b0;
    step();
    chk1("reset_not_busy", win.Busy_SO, 1'b0);
  endtask

  // Monitor: pops the scoreboard whenever the controller forwards an item downstream.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (prev_stall) chk1("stall_holds_valid", win.ValidOut_SO, 1'b1);
      if (prev_done) chk1("idle_after_done", win.Busy_SO, 1'b0);
      if (!win.ValidOut_SO) chk1("last_without_valid", win.LastOut_SO, 1'b0);
      if (win.ValidOut_SO && win.ReadyIn_SI) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", enc_head, -1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_item_index", enc_head, mon_e.id);
          chk1("out_last_flag", win.LastOut_SO, mon_e.last);
        end
      end
      if (win.Done_SO) begin
        chk("done_expected", (done_expected > 0) ? 1 : 0, 1);
        if (done_expected > 0) done_expected--;
        chk("done_with_outputs_left", exp_q.size(), 0);
      end
      prev_stall = win.ValidOut_SO & ~win.ReadyIn_SI;
      prev_done  = win.Done_SO;
    end
  end

  initial begin
    int len;
    win.Start_SI     = 1'b0;
    win.Abort_SI     = 1'b0;
    win.WindowLen_DI = '0;
    drive_inputs();
    step();
    step();
    chk("power_on_reset_outputs", int'(out_vec()), 0);
    rst   = 1'b0;
    quiet = 1'b0;
    step();

    run_window(6, 0, -1, 1'b0);
    run_window(2, 0, -1, 1'b0);
    run_window(0, 0, -1, 1'b0);
    run_window(6, 5, -1, 1'b0);
    run_window(10, 0, 3, 1'b1);
    run_window(5, 0, -1, 1'b0);
    reset_mid_run();
    run_window(NGRAM, 0, -1, 1'b0);
    run_window(NGRAM - 1, 0, -1, 1'b0);

    for (int w = 0; w < 25; w++) begin
      p_valid = 40 + int'($urandom_range(60));
      p_enc   = 40 + int'($urandom_range(60));
      p_ready = 40 + int'($urandom_range(60));
      len     = int'($urandom_range(12));
      run_window(len, (len >= NGRAM && $urandom_range(1) == 1) ? 3 : 0, -1, 1'b0);
    end

    p_valid = 100;
    p_enc   = 100;
    p_ready = 100;
    run_window(6, 0, -1, 1'b0);
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
